// File: rtl/femto8_io_pkg.sv
// rtl/femto8_io_pkg.sv - femto8 I/O register map, status bit indices and UART TX states (FEMTO8_UART_PARITY_EN adds PARITY)
package femto8_io_pkg;

    localparam logic [7:0] DATA_ADDR_DEFAULT = 8'h0E;
    localparam logic [7:0] STAT_ADDR_DEFAULT = 8'h0F;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_PAR   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FEMTO8_UART_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

endpackage

// File: rtl/femto8_sync_fifo.sv
// rtl/femto8_sync_fifo.sv - single-clock FIFO with registered pointers and occupancy count
module femto8_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/femto8_uart_tx.sv
// rtl/femto8_uart_tx.sv - memory-mapped 8N1 UART transmitter for the femto8 bus; FEMTO8_UART_PARITY_EN adds even parity
module femto8_uart_tx
    import femto8_io_pkg::*;
#(
    parameter logic [7:0] DATA_ADDR    = DATA_ADDR_DEFAULT,
    parameter logic [7:0] STAT_ADDR    = STAT_ADDR_DEFAULT,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] wdata,
    input  logic       write,
    output logic       sel,
    output logic [7:0] rdata,
    output logic       txd,
    output logic       busy
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef FEMTO8_UART_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    tx_state_t      state, state_n;
    logic [TW-1:0]  timer, timer_n;
    logic [2:0]     bit_idx, bit_n;
    logic [7:0]     shift, shift_n;
    logic           txd_n;
    logic           ovf;
    logic           pop;
    logic           bit_done;

    logic [7:0]     fifo_head;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           st_full, st_empty;

    logic push_req, push_ok, ovf_set, ovf_clr;

    assign push_req = write && (address == DATA_ADDR);
    // A pop on the same edge frees a slot, so a full FIFO can still accept.
    assign push_ok  = push_req && (!fifo_full || pop);
    assign ovf_set  = push_req && fifo_full && !pop;
    assign ovf_clr  = write && (address == STAT_ADDR) && wdata[ST_OVF];

    femto8_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .wdata (wdata),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign st_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign st_empty = (fifo_count == '0);
    assign bit_done = (timer == TW'(CLKS_PER_BIT - 1));

`ifdef FEMTO8_UART_PARITY_EN
    logic par_bit;
    always_ff @(posedge clk) begin
        if (reset)    par_bit <= 1'b0;
        else if (pop) par_bit <= ^fifo_head;
    end
`endif

    always_comb begin
        state_n = state;
        timer_n = timer;
        bit_n   = bit_idx;
        shift_n = shift;
        txd_n   = txd;
        pop     = 1'b0;
        if (state != IDLE) timer_n = bit_done ? '0 : timer + 1'b1;
        case (state)
            IDLE: begin
                txd_n   = 1'b1;
                timer_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_head;
                    txd_n   = 1'b0;
                    state_n = START;
                end
            end
            START: if (bit_done) begin
                txd_n   = shift[0];
                bit_n   = 3'd0;
                state_n = DATA;
            end
            DATA: if (bit_done) begin
                if (bit_idx == 3'd7) begin
`ifdef FEMTO8_UART_PARITY_EN
                    txd_n   = par_bit;
                    state_n = PARITY;
`else
                    txd_n   = 1'b1;
                    state_n = STOP;
`endif
                end else begin
                    shift_n = {1'b0, shift[7:1]};
                    txd_n   = shift[1];
                    bit_n   = bit_idx + 3'd1;
                end
            end
`ifdef FEMTO8_UART_PARITY_EN
            PARITY: if (bit_done) begin
                txd_n   = 1'b1;
                state_n = STOP;
            end
`endif
            STOP: if (bit_done) begin
                // Chain straight into the next start bit when data is waiting.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_head;
                    txd_n   = 1'b0;
                    state_n = START;
                end else begin
                    txd_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                txd_n   = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            txd     <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            txd     <= txd_n;
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    assign busy  = (state != IDLE);
    assign sel   = (address == DATA_ADDR) || (address == STAT_ADDR);
    assign rdata = (address == STAT_ADDR) ? {3'b000, PAR_ON, ovf, busy, st_full, st_empty} : 8'h00;

endmodule

// File: tb/tb_femto8_uart_tx.sv
// tb/tb_femto8_uart_tx.sv - randomized self-checking bench for femto8_uart_tx against a bit-stream frame model
module tb_femto8_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef FEMTO8_UART_PARITY_EN
    localparam logic [7:0] PAR_ST = 8'h10;
`else
    localparam logic [7:0] PAR_ST = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic [7:0] wdata;
    logic       write;
    logic       sel;
    logic [7:0] rdata;
    logic       txd;
    logic       busy;

    int vectors    = 0;
    int miscompares = 0;
    bit exp_q[$];

    femto8_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .wdata   (wdata),
        .write   (write),
        .sel     (sel),
        .rdata   (rdata),
        .txd     (txd),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line level for each clock of one frame: start, LSB-first data, [parity], stop.
    function automatic void add_frame(input logic [7:0] b);
        for (int c = 0; c < CPB; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) exp_q.push_back(b[i]);
`ifdef FEMTO8_UART_PARITY_EN
        for (int c = 0; c < CPB; c++) exp_q.push_back(^b);
`endif
        for (int c = 0; c < CPB; c++) exp_q.push_back(1'b1);
    endfunction

    task automatic test_reset;
        reset = 1'b1; address = 8'h00; wdata = 8'h00; write = 1'b0;
        repeat (3) tick;
        reset = 1'b0;
        address = 8'h0F;
        tick;
        vectors++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_line: txd=%b busy=%b want txd=1 busy=0", txd, busy);
        end
        vectors++;
        if (sel !== 1'b1 || rdata !== (8'h01 | PAR_ST)) begin
            miscompares++;
            $display("FAIL reset_status: sel=%b rdata=%h want sel=1 rdata=%h", sel, rdata, 8'h01 | PAR_ST);
        end
        address = 8'h10; #1;
        vectors++;
        if (sel !== 1'b0 || rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL decode_other: sel=%b rdata=%h want sel=0 rdata=00", sel, rdata);
        end
        address = 8'h0E; #1;
        vectors++;
        if (sel !== 1'b1 || rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL decode_data: sel=%b rdata=%h want sel=1 rdata=00", sel, rdata);
        end
    endtask

    task automatic test_stream(input logic [7:0] bytes[$], input string name);
        exp_q.delete();
        foreach (bytes[i]) add_frame(bytes[i]);
        address = 8'h0E; wdata = bytes[0]; write = 1'b1;
        tick;
        for (int k = 1; k <= exp_q.size(); k++) begin
            if (k < bytes.size()) begin
                wdata = bytes[k]; write = 1'b1;
            end else begin
                write = 1'b0;
            end
            tick;
            vectors++;
            if (txd !== exp_q[k-1] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s sample %0d: txd=%b busy=%b want txd=%b busy=1", name, k, txd, busy, exp_q[k-1]);
            end
        end
        write = 1'b0;
        tick;
        vectors++;
        if (txd !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_after: txd=%b busy=%b want txd=1 busy=0", name, txd, busy);
        end
    endtask

    task automatic test_single_frame;
        logic [7:0] q[$];
        q.push_back(8'hA5);
        test_stream(q, "single_a5");
        q.delete();
        q.push_back(8'h07);
        test_stream(q, "single_07");
    endtask

    task automatic test_back_to_back;
        logic [7:0] q[$];
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        test_stream(q, "back_to_back");
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            logic [7:0] q[$];
            int n;
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            test_stream(q, "random_burst");
        end
    endtask

    // Six writes into an idle unit: first is popped, next four fill the FIFO, sixth overflows.
    task automatic test_overflow;
        logic [7:0] b[6];
        foreach (b[i]) b[i] = 8'($urandom);
        exp_q.delete();
        for (int i = 0; i < 5; i++) add_frame(b[i]);
        address = 8'h0E; wdata = b[0]; write = 1'b1;
        tick;
        for (int k = 1; k <= exp_q.size(); k++) begin
            if (k < 6) begin
                address = 8'h0E; wdata = b[k]; write = 1'b1;
            end else if (k == 7) begin
                address = 8'h0F; wdata = 8'h08; write = 1'b1;
            end else begin
                address = 8'h0F; write = 1'b0;
            end
            tick;
            vectors++;
            if (txd !== exp_q[k-1]) begin
                miscompares++;
                $display("FAIL overflow_line sample %0d: txd=%b want %b", k, txd, exp_q[k-1]);
            end
            if (k == 6) begin
                vectors++;
                if (sel !== 1'b1 || rdata !== (8'h0E | PAR_ST)) begin
                    miscompares++;
                    $display("FAIL overflow_status: sel=%b rdata=%h want sel=1 rdata=%h", sel, rdata, 8'h0E | PAR_ST);
                end
            end
            if (k == 7) begin
                vectors++;
                if (rdata !== (8'h06 | PAR_ST)) begin
                    miscompares++;
                    $display("FAIL ovf_clear: rdata=%h want %h", rdata, 8'h06 | PAR_ST);
                end
            end
        end
        write = 1'b0;
        tick;
        vectors++;
        if (rdata !== (8'h01 | PAR_ST) || txd !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_drained: rdata=%h txd=%b want rdata=%h txd=1", rdata, txd, 8'h01 | PAR_ST);
        end
    endtask

    task automatic test_reset_midframe;
        int lows;
        logic [7:0] b0, b1;
        b0 = 8'($urandom); b1 = 8'($urandom);
        exp_q.delete();
        add_frame(b0);
        address = 8'h0E; wdata = b0; write = 1'b1;
        tick;
        wdata = b1;
        for (int k = 1; k <= 12; k++) begin
            tick;
            write = 1'b0;
            vectors++;
            if (txd !== exp_q[k-1]) begin
                miscompares++;
                $display("FAIL midframe_line sample %0d: txd=%b want %b", k, txd, exp_q[k-1]);
            end
        end
        reset = 1'b1; address = 8'h0F;
        tick;
        reset = 1'b0;
        vectors++;
        if (txd !== 1'b1 || busy !== 1'b0 || rdata !== (8'h01 | PAR_ST)) begin
            miscompares++;
            $display("FAIL midframe_reset: txd=%b busy=%b rdata=%h want txd=1 busy=0 rdata=%h", txd, busy, rdata, 8'h01 | PAR_ST);
        end
        lows = 0;
        for (int k = 0; k < 50; k++) begin
            tick;
            if (txd !== 1'b1 || busy !== 1'b0) lows++;
        end
        vectors++;
        if (lows != 0) begin
            miscompares++;
            $display("FAIL post_reset_quiet: active_cycles=%0d want 0", lows);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_back_to_back;
        test_overflow;
        test_random;
        test_reset_midframe;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
